// File: rtl/serial_parity_checker.sv
// Receive side of the XOR parity link: deserialises start/data/parity/stop
// frames, recomputes parity on the fly and reports the word plus status flags.
//
// state   | meaning
// --------+-------------------------------------------------------------
// sIdle   | line idle, waiting for a 0 start bit
// sData   | shifting in DATA_W data bits, LSB first, running XOR parity
// sParity | comparing received parity bit against the running XOR
// sStop   | expecting stop=1; publishes word or flags a framing error
module serial_parity_checker #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CntW = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MsbOne = {{(DATA_W-1){1'b0}}, 1'b1} << (DATA_W - 1);

  typedef enum logic [1:0] {sIdle, sData, sParity, sStop} stateT;

  stateT             state;
  logic [CntW-1:0]   bitCnt;
  logic              runPar;
  logic              frameParErr;
  logic [DATA_W-1:0] shiftReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= sIdle;
      bitCnt      <= '0;
      runPar      <= 1'b0;
      frameParErr <= 1'b0;
      shiftReg    <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_valid) begin
        case (state)
          sIdle: begin
            if (!bit_in) begin
              state    <= sData;
              bitCnt   <= '0;
              runPar   <= 1'b0;
              shiftReg <= '0;
            end
          end
          sData: begin
            // Shifting in from the MSB leaves the first data bit at the LSB
            // once all DATA_W bits have arrived.
            shiftReg <= (shiftReg >> 1) | (bit_in ? MsbOne : '0);
            runPar   <= runPar ^ bit_in;
            bitCnt   <= bitCnt + CntW'(1);
            if (bitCnt == CntW'(DATA_W - 1)) begin
              state <= sParity;
            end
          end
          sParity: begin
            frameParErr <= runPar ^ bit_in ^ ODD;
            state       <= sStop;
          end
          sStop: begin
            if (bit_in) begin
              data_out   <= shiftReg;
              parity_err <= frameParErr;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= sIdle;
          end
          default: state <= sIdle;
        endcase
      end
    end
  end

  assign busy = (state != sIdle);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even- and odd-parity instances share one
// serial line and are compared against a frame-level queue model every cycle.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b1;
  logic       bit_valid = 1'b0;
  logic [7:0] dataOutE, dataOutO;
  logic       dvE, dvO, perrE, perrO, feE, feO, busyE, busyO;

  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(8), .ODD(1'b0)) dutE (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(dataOutE), .data_valid(dvE), .parity_err(perrE),
    .frame_err(feE), .busy(busyE));

  serial_parity_checker #(.DATA_W(8), .ODD(1'b1)) dutO (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(dataOutO), .data_valid(dvO), .parity_err(perrO),
    .frame_err(feO), .busy(busyO));

  // Frame-level model: collect the bits after a start bit; once data, parity
  // and stop are in hand, evaluate the whole frame arithmetically.
  bit         mInFrame = 1'b0;
  int         mQ[$];
  logic [7:0] mData = '0;
  logic       mPerrE = 1'b0, mPerrO = 1'b0, mDv = 1'b0, mFe = 1'b0;
  int         mWord, mOnes;

  always @(posedge clk) begin
    mDv = 1'b0;
    mFe = 1'b0;
    if (rst) begin
      mInFrame = 1'b0;
      mQ.delete();
      mData = '0;
      mPerrE = 1'b0;
      mPerrO = 1'b0;
    end else if (bit_valid) begin
      if (!mInFrame) begin
        if (bit_in == 1'b0) begin
          mInFrame = 1'b1;
          mQ.delete();
        end
      end else begin
        mQ.push_back(int'(bit_in));
        if (mQ.size() == 10) begin
          mWord = 0;
          mOnes = 0;
          for (int i = 0; i < 8; i++) begin
            mWord += mQ[i] * (1 << i);
            mOnes += mQ[i];
          end
          if (mQ[9] == 1) begin
            mData  = 8'(mWord);
            mPerrE = ((mOnes + mQ[8]) % 2) != 0;
            mPerrO = ((mOnes + mQ[8] + 1) % 2) != 0;
            mDv    = 1'b1;
          end else begin
            mFe = 1'b1;
          end
          mInFrame = 1'b0;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      cmp("cycleEven", {dataOutE, dvE, perrE, feE, busyE}, {mData, mDv, mPerrE, mFe, mInFrame});
      cmp("cycleOdd",  {dataOutO, dvO, perrO, feO, busyO}, {mData, mDv, mPerrO, mFe, mInFrame});
    end
  end

  task automatic drive(input logic r, input logic v, input logic b);
    @(negedge clk);
    rst = r;
    bit_valid = v;
    bit_in = b;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic p, input logic s,
                           input bit gaps, input bit withStart);
    if (withStart) drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0, 1'($urandom));
      drive(1'b0, 1'b1, d[i]);
    end
    drive(1'b0, 1'b1, p);
    drive(1'b0, 1'b1, s);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    bit         gaps;
    int         idlePre;
    logic       expDv;
    logic       expFe;
    logic [7:0] expData;
    logic       expPerrE;
    logic       expPerrO;
  } vecT;

  vecT vecs[5];
  logic [9:0] rBits;
  int abortAt;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[3] = '{8'h81, 1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};

    repeat (3) drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    checkOn = 1'b1;
    cmp("resetEven", {dataOutE, dvE, perrE, feE, busyE}, 12'h000);
    cmp("resetOdd",  {dataOutO, dvO, perrO, feO, busyO}, 12'h000);

    for (int k = 0; k < 5; k++) begin
      repeat (vecs[k].idlePre) drive(1'b0, 1'b1, 1'b1);
      if (vecs[k].idlePre > 0) cmp("idleBusy", 12'(busyE), 12'h0);
      sendFrame(vecs[k].data, vecs[k].par, vecs[k].stop, vecs[k].gaps, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      cmp("vecValid",    12'(dvE),      12'(vecs[k].expDv));
      cmp("vecFrameErr", 12'(feE),      12'(vecs[k].expFe));
      cmp("vecData",     12'(dataOutE), 12'(vecs[k].expData));
      cmp("vecPerrEven", 12'(perrE),    12'(vecs[k].expPerrE));
      cmp("vecPerrOdd",  12'(perrO),    12'(vecs[k].expPerrO));
      cmp("vecBusy",     12'(busyE),    12'h0);
    end

    // Reset in the middle of a frame discards it entirely.
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    cmp("midFrameBusy", 12'(busyE), 12'h1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    cmp("midResetEven", {dataOutE, dvE, perrE, feE, busyE}, 12'h000);
    cmp("midResetOdd",  {dataOutO, dvO, perrO, feO, busyO}, 12'h000);
    sendFrame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    cmp("afterResetData", {dataOutE, dvE, perrE, perrO}, {8'h5A, 1'b1, 1'b0, 1'b1});

    // Back-to-back frames on the odd-parity instance.
    sendFrame(8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    cmp("b2bFirst", {dataOutO, dvO, perrO, busyO}, {8'h07, 1'b1, 1'b0, 1'b0});
    drive(1'b0, 1'b1, 1'b0);
    cmp("b2bBusy", 12'(busyO), 12'h1);
    repeat (7) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    cmp("b2bSecond", {dataOutO, dvO, perrO, busyO}, {8'h00, 1'b1, 1'b0, 1'b0});

    // Random frames, gaps, idle bits, framing errors and aborting resets.
    repeat (300) begin
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom), 1'b1);
      rBits = {($urandom_range(0, 4) != 0), 1'($urandom), 8'($urandom)};
      abortAt = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 9)) : -1;
      drive(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'($urandom));
        if (i == abortAt) begin
          drive(1'b1, 1'b1, rBits[i]);
          break;
        end
        drive(1'b0, 1'b1, rBits[i]);
      end
    end
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    checkOn = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
